// File: rtl/input_conditioner_pkg.sv
// Shared constants for the board-input conditioner.
// Latency: none (constants only).
// Backpressure: none.
package input_conditioner_pkg;

   // 10 ms of stable input at 50 MHz.
   localparam int DEBOUNCE_10MS = 500000;
   // Short window so simulations settle in a handful of cycles.
   localparam int DEBOUNCE_SIM  = 4;

   // Raw pin level meaning "not active" for each input type.
   localparam logic KEY_RST_LEVEL = 1'b1;   // pushbuttons are active-low, so released reads 1
   localparam logic SW_RST_LEVEL  = 1'b0;   // switch off reads 0

endpackage

// File: rtl/debounce_bit.sv
// One input bit: two-flop synchronizer, stability counter, clean level and edge pulses.
// Latency: a held change reaches level DEBOUNCE_CYCLES+2 edges after first sample; pulses align with the new level.
// Backpressure: none; rise/fall are single-cycle and must be sampled every cycle.
module debounce_bit #(
   parameter int   DEBOUNCE_CYCLES = 4,
   parameter int   CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
   parameter logic RST_LEVEL       = 1'b0,
   parameter logic INVERT          = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);

   logic             sync1;
   logic             sync2;
   logic             s;
   logic [CNT_W-1:0] cnt;
   logic             accept;

   // Two-stage synchronizer; resets to the inactive pin level so no false edge appears.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= RST_LEVEL;
         sync2 <= RST_LEVEL;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Internal active-high view of the synchronized input.
   assign s      = sync2 ^ INVERT;
   assign accept = (s != level) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

   // Count consecutive disagreeing cycles; any agreement throws away partial progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (s == level) begin
         cnt   <= '0;
      end else if (accept) begin
         level <= s;
         cnt   <= '0;
      end else begin
         cnt   <= cnt + CNT_W'(1);
      end
   end

   // Pulses are registered on the same edge as the level so they coincide with its first new cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= accept &  s;
         fall <= accept & ~s;
      end
   end

endmodule

// File: rtl/input_conditioner.sv
// Conditions raw KEY/SW pins into clean debounced levels plus press/release/change pulses.
// Latency: DEBOUNCE_CYCLES+2 CLOCK_50 edges from first sample of a held change to level and pulse.
// Backpressure: none; pulses last one cycle and consumers must sample every cycle.
module input_conditioner
   import input_conditioner_pkg::*;
#(
   parameter int N_KEYS          = 4,
   parameter int N_SW            = 10,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic [N_KEYS-1:0] KEY,
   input  logic [N_SW-1:0]   SW,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_SW-1:0]   sw_level,
   output logic [N_SW-1:0]   sw_change
);

   logic [N_SW-1:0] sw_rise;
   logic [N_SW-1:0] sw_fall;

   // Pushbuttons: active-low pins, inverted after the synchronizer.
   for (genvar i = 0; i < N_KEYS; i++) begin : g_key
      debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W),
         .RST_LEVEL       (KEY_RST_LEVEL),
         .INVERT          (1'b1)
      ) u_key (
         .clk   (CLOCK_50),
         .rst   (reset),
         .raw   (KEY[i]),
         .level (key_level[i]),
         .rise  (key_press[i]),
         .fall  (key_release[i])
      );
   end

   // Slide switches: active-high pins, used as-is.
   for (genvar i = 0; i < N_SW; i++) begin : g_sw
      debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W),
         .RST_LEVEL       (SW_RST_LEVEL),
         .INVERT          (1'b0)
      ) u_sw (
         .clk   (CLOCK_50),
         .rst   (reset),
         .raw   (SW[i]),
         .level (sw_level[i]),
         .rise  (sw_rise[i]),
         .fall  (sw_fall[i])
      );
   end

   // A switch reports any change, in either direction.
   assign sw_change = sw_rise | sw_fall;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench: directed scenarios then random pin activity against a window-based model.
// Latency: expects level/pulse DEBOUNCE_SIM+2 edges after first sample.
// Backpressure: none.
module tb_input_conditioner;
   import input_conditioner_pkg::*;

   localparam int N_KEYS = 4;
   localparam int N_SW   = 10;
   localparam int NB     = N_KEYS + N_SW;
   localparam int D      = DEBOUNCE_SIM;

   logic              CLOCK_50 = 1'b0;
   logic              reset    = 1'b0;
   logic [N_KEYS-1:0] KEY      = '1;
   logic [N_SW-1:0]   SW       = '0;
   logic [N_KEYS-1:0] key_level, key_press, key_release;
   logic [N_SW-1:0]   sw_level, sw_change;

   int checks = 0;
   int errors = 0;

   // Model state: last D+2 sampled active-high inputs (keys low bits, switches high bits).
   logic [NB-1:0] hist [$];
   logic [NB-1:0] q_m, rise_m, fall_m;

   input_conditioner #(
      .N_KEYS          (N_KEYS),
      .N_SW            (N_SW),
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .CLOCK_50    (CLOCK_50),
      .reset       (reset),
      .KEY         (KEY),
      .SW          (SW),
      .key_level   (key_level),
      .key_press   (key_press),
      .key_release (key_release),
      .sw_level    (sw_level),
      .sw_change   (sw_change)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NB-1:0] raw_active();
      return {SW, ~KEY};
   endfunction

   task automatic model_reset();
      hist.delete();
      for (int j = 0; j < D + 2; j++) hist.push_back('0);
      q_m    = '0;
      rise_m = '0;
      fall_m = '0;
   endtask

   // A bit takes a new value once its oldest D synchronized samples all agree on it.
   task automatic model_edge();
      logic all1, all0;
      hist.push_back(raw_active());
      void'(hist.pop_front());
      for (int b = 0; b < NB; b++) begin
         all1 = 1'b1;
         all0 = 1'b1;
         for (int j = 0; j < D; j++) begin
            if (hist[j][b]) all0 = 1'b0;
            else            all1 = 1'b0;
         end
         rise_m[b] = 1'b0;
         fall_m[b] = 1'b0;
         if (all1 && !q_m[b]) begin
            q_m[b] = 1'b1; rise_m[b] = 1'b1;
         end else if (all0 && q_m[b]) begin
            q_m[b] = 1'b0; fall_m[b] = 1'b1;
         end
      end
   endtask

   task automatic check_all(input string ctx);
      chk({ctx, ":key_level"},   32'(key_level),   32'(q_m[N_KEYS-1:0]));
      chk({ctx, ":key_press"},   32'(key_press),   32'(rise_m[N_KEYS-1:0]));
      chk({ctx, ":key_release"}, 32'(key_release), 32'(fall_m[N_KEYS-1:0]));
      chk({ctx, ":sw_level"},    32'(sw_level),    32'(q_m[NB-1:N_KEYS]));
      chk({ctx, ":sw_change"},   32'(sw_change),   32'(rise_m[NB-1:N_KEYS] | fall_m[NB-1:N_KEYS]));
   endtask

   // One clock edge: advance the model, then compare everything 1 ns later.
   task automatic step(input string ctx);
      @(posedge CLOCK_50);
      if (reset) model_reset();
      else       model_edge();
      #1;
      check_all(ctx);
   endtask

   // Run n edges and report the first edge (1-based) where the watched pulse fires and how many pulses fired.
   // kind: 0 = key_press[bit], 1 = key_release[bit], 2 = any sw_change.
   task automatic watch(input string ctx, input int kind, input int bit_i, input int n,
                        output int first_edge, output int pulses);
      logic hit;
      first_edge = -1;
      pulses     = 0;
      for (int e = 1; e <= n; e++) begin
         step(ctx);
         case (kind)
            0:       hit = key_press[bit_i];
            1:       hit = key_release[bit_i];
            default: hit = |sw_change;
         endcase
         if (hit) begin
            pulses++;
            if (first_edge < 0) first_edge = e;
         end
      end
   endtask

   initial begin
      int fe, np;

      // Reset asserted between edges must clear outputs without a clock.
      model_reset();
      #3 reset = 1'b1;
      #1;
      chk("rst_imm_key_level", 32'(key_level), 32'h0);
      chk("rst_imm_sw_level",  32'(sw_level),  32'h0);
      chk("rst_imm_pulses",    32'({key_press, key_release, sw_change}), 32'h0);
      step("rst_hold");
      step("rst_hold");
      reset = 1'b0;
      for (int i = 0; i < 4; i++) step("post_rst");

      // Clean press on KEY[1].
      KEY[1] = 1'b0;
      watch("press", 0, 1, 10, fe, np);
      chk("press_edge",   32'(fe), 32'(D + 2));
      chk("press_count",  32'(np), 32'd1);
      chk("press_level",  32'(key_level), 32'h2);

      // Release KEY[1].
      KEY[1] = 1'b1;
      watch("release", 1, 1, 10, fe, np);
      chk("release_edge",  32'(fe), 32'(D + 2));
      chk("release_count", 32'(np), 32'd1);
      chk("release_level", 32'(key_level), 32'h0);

      // Bounce: 2-cycle runs never reach the debounce window.
      np = 0;
      for (int i = 0; i < 12; i++) begin
         KEY[1] = (i / 2) % 2 == 0 ? 1'b0 : 1'b1;
         step("bounce");
         if (key_press[1] || key_release[1]) np++;
      end
      chk("bounce_pulses", 32'(np), 32'd0);
      KEY[1] = 1'b0;
      watch("settle", 0, 1, 10, fe, np);
      chk("settle_edge",  32'(fe), 32'(D + 2));
      chk("settle_count", 32'(np), 32'd1);
      KEY[1] = 1'b1;
      for (int i = 0; i < 10; i++) step("settle_rel");

      // Two switches change together.
      SW = 10'h003;
      watch("sw", 2, 0, 10, fe, np);
      chk("sw_edge",  32'(fe), 32'(D + 2));
      chk("sw_count", 32'(np), 32'd1);
      chk("sw_level", 32'(sw_level), 32'h003);

      // Reset in the middle of a KEY[0] count, key still held afterwards.
      KEY[0] = 1'b0;
      for (int i = 0; i < 4; i++) step("midcnt");
      #2 reset = 1'b1;
      #1;
      chk("midrst_sw_level", 32'(sw_level), 32'h0);
      chk("midrst_key",      32'({key_level, key_press}), 32'h0);
      step("midrst_hold");
      step("midrst_hold");
      reset = 1'b0;
      watch("after_rst", 0, 0, 12, fe, np);
      chk("after_rst_edge",  32'(fe), 32'(D + 2));
      chk("after_rst_count", 32'(np), 32'd1);
      chk("after_rst_sw",    32'(sw_level), 32'h003);

      // Random pin activity: mostly slow changes with occasional short glitch bursts.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) KEY[$urandom_range(0, N_KEYS - 1)] ^= 1'b1;
         if ($urandom_range(0, 5) == 0) SW[$urandom_range(0, N_SW - 1)]   ^= 1'b1;
         step("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
